// File: rtl/chnl_tx_mux.sv
// chnl_tx_mux: NUM_SRC buffered input streams time-shared onto one RIFFA TX channel, one header beat + payload per transfer.
// Optional CHNL_TX_MUX_PAD_EN: idle-timeout sends are zero-padded up to the alignment instead of rounded down.
module chnl_tx_mux #(
    parameter int C_PCI_DATA_WIDTH = 64,
    parameter int NUM_SRC          = 4,
    parameter int FIFO_DEPTH       = 512,
    parameter int CHNL_ALIGN       = 4,
    parameter int MAX_LENGTH       = 64,
    parameter int MAX_IDLE_CYCLES  = 128
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_SRC-1:0]                  i_val,
    output logic [NUM_SRC-1:0]                  i_rdy,
    input  logic [NUM_SRC*C_PCI_DATA_WIDTH-1:0] i_data,
    output logic                                CHNL_TX_CLK,
    output logic                                CHNL_TX,
    input  logic                                CHNL_TX_ACK,
    output logic                                CHNL_TX_LAST,
    output logic [31:0]                         CHNL_TX_LEN,
    output logic [30:0]                         CHNL_TX_OFF,
    output logic [C_PCI_DATA_WIDTH-1:0]         CHNL_TX_DATA,
    output logic                                CHNL_TX_DATA_VALID,
    input  logic                                CHNL_TX_DATA_REN,
    output logic [7:0]                          o_active_src
);
    localparam int W         = C_PCI_DATA_WIDTH;
    localparam int ALIGN     = CHNL_ALIGN * 32 / W;
    localparam int MAX_BEATS = MAX_LENGTH * 32 / W;
    localparam int AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW        = $clog2(FIFO_DEPTH + 1);
    localparam int IW        = (MAX_IDLE_CYCLES > 0) ? $clog2(MAX_IDLE_CYCLES + 1) : 1;
    localparam int SW        = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    localparam logic [CW-1:0] BEATS_MAX   = CW'(MAX_BEATS);
    localparam logic [CW-1:0] BEATS_ALN   = CW'(ALIGN);
    localparam logic [CW-1:0] DEPTH_C     = CW'(FIFO_DEPTH);
    localparam logic [IW-1:0] IDLE_MAX    = IW'(MAX_IDLE_CYCLES);
    localparam logic [31:0]   DW_PER_BEAT = 32'(W / 32);
    localparam logic [SW-1:0] LAST_SRC    = SW'(NUM_SRC - 1);

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA} state_t;

    state_t        state, state_nxt;
    logic          tx_q;
    logic [SW-1:0] src_q;
    logic [SW-1:0] rr_ptr;
    logic [CW-1:0] pay_q;
    logic [CW-1:0] fill_q;
    logic [CW-1:0] beat_q;

    logic [W-1:0]  mem    [NUM_SRC][FIFO_DEPTH];
    logic [AW-1:0] wr_ptr [NUM_SRC];
    logic [AW-1:0] rd_ptr [NUM_SRC];
    logic [CW-1:0] occ    [NUM_SRC];
    logic [IW-1:0] idle   [NUM_SRC];
    logic [CW-1:0] pay_s  [NUM_SRC];
    logic [CW-1:0] fill_s [NUM_SRC];

    logic [NUM_SRC-1:0] push;
    logic [NUM_SRC-1:0] pop;
    logic [NUM_SRC-1:0] elig;
    logic               found;
    logic               grant;
    logic [SW-1:0]      gnt_src;
    logic               data_beat;
    logic               last_beat;
    logic [31:0]        pay_dw;
    logic               unused_ack;

    assign unused_ack   = CHNL_TX_ACK;
    assign CHNL_TX_CLK  = clk;
    assign CHNL_TX_LAST = 1'b1;
    assign CHNL_TX_OFF  = '0;

    // Input handshake and FIFO pop; padding beats (beat_q >= fill_q) never pop.
    assign data_beat = (state == S_DATA) && CHNL_TX_DATA_REN;
    assign last_beat = (beat_q == pay_q - CW'(1));
    assign grant     = (state == S_IDLE) && found;

    always_comb begin
        for (int s = 0; s < NUM_SRC; s++) begin
            i_rdy[s] = (occ[s] != DEPTH_C);
            push[s]  = i_val[s] && i_rdy[s];
            pop[s]   = data_beat && (src_q == SW'(s)) && (beat_q < fill_q);
        end
    end

    // Eligibility and candidate payload per source.
    always_comb begin
        logic          timed_out;
        logic [CW-1:0] rem;
        logic [CW-1:0] base;
        timed_out = 1'b0;
        rem       = '0;
        base      = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            elig[s]   = 1'b0;
            pay_s[s]  = '0;
            fill_s[s] = '0;
            timed_out = (MAX_IDLE_CYCLES != 0) && (idle[s] >= IDLE_MAX);
            rem       = occ[s] % BEATS_ALN;
            base      = occ[s] - rem;
            if (occ[s] >= BEATS_MAX) begin
                elig[s]   = 1'b1;
                pay_s[s]  = BEATS_MAX;
                fill_s[s] = BEATS_MAX;
            end else if (timed_out) begin
`ifdef CHNL_TX_MUX_PAD_EN
                if (occ[s] != '0) begin
                    elig[s]   = 1'b1;
                    pay_s[s]  = (rem != '0) ? base + BEATS_ALN : base;
                    fill_s[s] = occ[s];
                end
`else
                if (occ[s] >= BEATS_ALN) begin
                    elig[s]   = 1'b1;
                    pay_s[s]  = base;
                    fill_s[s] = base;
                end
`endif
            end
        end
    end

    // Round-robin: first eligible source at or after rr_ptr.
    always_comb begin
        int idx;
        idx     = 0;
        found   = 1'b0;
        gnt_src = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            idx = (int'(rr_ptr) + i) % NUM_SRC;
            if (!found && elig[idx]) begin
                found   = 1'b1;
                gnt_src = SW'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            tx_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            tx_q  <= (state_nxt != S_IDLE);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (found) state_nxt = S_HDR;
            S_HDR:   if (CHNL_TX_DATA_REN) state_nxt = S_DATA;
            S_DATA:  if (CHNL_TX_DATA_REN && last_beat) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign pay_dw = 32'(pay_q) * DW_PER_BEAT;

    always_comb begin
        CHNL_TX            = tx_q;
        CHNL_TX_DATA_VALID = (state != S_IDLE);
        CHNL_TX_LEN        = pay_dw + DW_PER_BEAT;
        o_active_src       = tx_q ? 8'(src_q) : 8'd0;
        CHNL_TX_DATA       = '0;
        if (state == S_HDR) begin
            CHNL_TX_DATA[7:0]  = 8'(src_q);
            CHNL_TX_DATA[31:8] = pay_dw[23:0];
        end else if (state == S_DATA && beat_q < fill_q) begin
            CHNL_TX_DATA = mem[src_q][rd_ptr[src_q]];
        end
    end

    always_ff @(posedge clk) begin
        for (int s = 0; s < NUM_SRC; s++) begin
            if (push[s]) mem[s][wr_ptr[s]] <= i_data[s*W +: W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            src_q  <= '0;
            rr_ptr <= '0;
            pay_q  <= '0;
            fill_q <= '0;
            beat_q <= '0;
            for (int s = 0; s < NUM_SRC; s++) begin
                wr_ptr[s] <= '0;
                rd_ptr[s] <= '0;
                occ[s]    <= '0;
                idle[s]   <= '0;
            end
        end else begin
            for (int s = 0; s < NUM_SRC; s++) begin
                if (push[s]) wr_ptr[s] <= wr_ptr[s] + AW'(1);
                if (pop[s])  rd_ptr[s] <= rd_ptr[s] + AW'(1);
                occ[s] <= occ[s] + CW'(push[s]) - CW'(pop[s]);
                if (push[s] || (grant && gnt_src == SW'(s)))
                    idle[s] <= '0;
                else if (!i_val[s] && idle[s] < IDLE_MAX)
                    idle[s] <= idle[s] + IW'(1);
            end
            // Payload is frozen at grant; later arrivals wait for the next transfer.
            if (grant) begin
                src_q  <= gnt_src;
                pay_q  <= pay_s[gnt_src];
                fill_q <= fill_s[gnt_src];
                beat_q <= '0;
            end else if (data_beat) begin
                beat_q <= beat_q + CW'(1);
            end
            if (data_beat && last_beat)
                rr_ptr <= (src_q == LAST_SRC) ? '0 : src_q + SW'(1);
        end
    end
endmodule

// File: tb/tb_chnl_tx_mux.sv
module tb_chnl_tx_mux;
    localparam int W     = 64;
    localparam int NS    = 4;
    localparam int DEPTH = 512;
    localparam int IDLE  = 128;
    localparam int ALIGN = 4 * 32 / W;
    localparam int MAXB  = 64 * 32 / W;
`ifdef CHNL_TX_MUX_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NS-1:0]   i_val = '0;
    logic [NS-1:0]   i_rdy;
    logic [NS*W-1:0] i_data = '0;
    logic            tx_clk, tx, tx_last, tx_dv;
    logic            ack = 1'b0;
    logic            ren = 1'b0;
    logic [31:0]     tx_len;
    logic [30:0]     tx_off;
    logic [W-1:0]    tx_data;
    logic [7:0]      act_src;

    int checks = 0;
    int passes = 0;
    logic [W-1:0] mq [NS][$];
    logic [W-1:0] got[$];

    chnl_tx_mux #(.C_PCI_DATA_WIDTH(W), .NUM_SRC(NS), .FIFO_DEPTH(DEPTH), .CHNL_ALIGN(4),
                  .MAX_LENGTH(64), .MAX_IDLE_CYCLES(IDLE)) dut (
        .clk(clk), .rst(rst), .i_val(i_val), .i_rdy(i_rdy), .i_data(i_data),
        .CHNL_TX_CLK(tx_clk), .CHNL_TX(tx), .CHNL_TX_ACK(ack), .CHNL_TX_LAST(tx_last),
        .CHNL_TX_LEN(tx_len), .CHNL_TX_OFF(tx_off), .CHNL_TX_DATA(tx_data),
        .CHNL_TX_DATA_VALID(tx_dv), .CHNL_TX_DATA_REN(ren), .o_active_src(act_src));

    always #5 clk = ~clk;

    // Reference rules: payload chosen from occupancy and timeout state.
    function automatic int exp_payload(int occ, bit timed_out);
        if (occ >= MAXB) return MAXB;
        if (timed_out) return PAD ? ((occ + ALIGN - 1) / ALIGN) * ALIGN : (occ / ALIGN) * ALIGN;
        return 0;
    endfunction

    function automatic logic [W-1:0] exp_hdr(int src, int pay);
        return W'(pay * (W / 32)) << 8 | W'(src);
    endfunction

    function automatic int rr_pick(int ptr, logic [NS-1:0] mask);
        for (int i = 0; i < NS; i++) if (mask[(ptr + i) % NS]) return (ptr + i) % NS;
        return -1;
    endfunction

    task automatic reset_dut();
        rst = 1'b1; i_val = '0; ren = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int s = 0; s < NS; s++) mq[s].delete();
    endtask

    task automatic push_multi(input logic [NS-1:0] mask, input int n);
        logic [W-1:0] d;
        for (int k = 0; k < n; k++) begin
            for (int s = 0; s < NS; s++) begin
                if (mask[s]) begin
                    d = {$urandom(), $urandom()};
                    i_data[s*W +: W] = d;
                    if (i_rdy[s]) mq[s].push_back(d);
                end
            end
            i_val = mask;
            @(negedge clk);
        end
        i_val = '0;
    endtask

    // Captures one transfer (header + consumed beats); comparisons are left to the caller.
    task automatic collect(input bit toggle, output bit ok, output logic [31:0] len,
                           output logic [W-1:0] hdr, output logic [7:0] act, output int ncyc);
        int t;
        t = 0; ok = 1'b0; len = '0; hdr = '0; act = '0; ncyc = 0;
        got.delete();
        while (tx !== 1'b1 && t < 2000) begin @(negedge clk); t++; end
        if (tx !== 1'b1) return;
        len = tx_len; hdr = tx_data; act = act_src;
        ren = 1'b1;
        @(negedge clk);
        while (tx === 1'b1 && ncyc < 4000) begin
            ren = toggle ? (ncyc % 2 == 0) : 1'b1;
            if (tx_dv === 1'b1 && ren) got.push_back(tx_data);
            @(negedge clk);
            ncyc++;
        end
        ren = 1'b0;
        ok = 1'b1;
    endtask

    task automatic test_reset();
        reset_dut();
        checks++; if (tx !== 1'b0) $display("FAIL reset_tx: got %b want 0", tx); else passes++;
        checks++; if (tx_dv !== 1'b0) $display("FAIL reset_dv: got %b want 0", tx_dv); else passes++;
        checks++; if (act_src !== 8'd0) $display("FAIL reset_act: got %0d want 0", act_src); else passes++;
        checks++; if (i_rdy !== '1) $display("FAIL reset_rdy: got %b want 1111", i_rdy); else passes++;
        checks++; if (tx_last !== 1'b1 || tx_off !== '0)
            $display("FAIL const_last_off: got %b/%0h want 1/0", tx_last, tx_off); else passes++;
    endtask

    task automatic test_single();
        bit ok; logic [31:0] len; logic [W-1:0] hdr; logic [7:0] act; int ncyc, bad;
        reset_dut();
        push_multi(4'b0100, 32);
        checks++; if (tx !== 1'b0) $display("FAIL single_early: tx %b want 0", tx); else passes++;
        @(negedge clk);
        checks++; if (tx !== 1'b1) $display("FAIL single_latency: tx %b want 1", tx); else passes++;
        collect(1'b0, ok, len, hdr, act, ncyc);
        checks++; if (!ok || len !== 32'((1 + exp_payload(32, 0)) * 2))
            $display("FAIL single_len: got %0d want 66", len); else passes++;
        checks++; if (hdr !== exp_hdr(2, 32)) $display("FAIL single_hdr: got %h want %h", hdr, exp_hdr(2, 32)); else passes++;
        checks++; if (act !== 8'd2) $display("FAIL single_act: got %0d want 2", act); else passes++;
        bad = (got.size() != 32) ? 1 : 0;
        for (int k = 0; k < got.size() && mq[2].size() > 0; k++) if (got[k] !== mq[2].pop_front()) bad++;
        checks++; if (bad != 0) $display("FAIL single_data: %0d bad of %0d beats, want 0 bad of 32", bad, got.size()); else passes++;
    endtask

    task automatic test_timeout();
        bit ok; logic [31:0] len; logic [W-1:0] hdr; logic [7:0] act; int ncyc, bad, t, pay;
        logic [W-1:0] e;
        reset_dut();
        push_multi(4'b0001, 5);
        t = 0;
        while (tx !== 1'b1 && t < 1000) begin @(negedge clk); t++; end
        checks++; if (t != IDLE + 1) $display("FAIL timeout_wait: got %0d cycles want %0d", t, IDLE + 1); else passes++;
        pay = exp_payload(5, 1);
        collect(1'b0, ok, len, hdr, act, ncyc);
        checks++; if (!ok || len !== 32'((1 + pay) * 2)) $display("FAIL timeout_len: got %0d want %0d", len, (1 + pay) * 2); else passes++;
        checks++; if (hdr !== exp_hdr(0, pay)) $display("FAIL timeout_hdr: got %h want %h", hdr, exp_hdr(0, pay)); else passes++;
        bad = (got.size() != pay) ? 1 : 0;
        for (int k = 0; k < got.size(); k++) begin
            e = (mq[0].size() > 0) ? mq[0].pop_front() : '0;
            if (got[k] !== e) bad++;
        end
        checks++; if (bad != 0) $display("FAIL timeout_data: %0d bad, got %0d beats want %0d", bad, got.size(), pay); else passes++;
        t = 0;
        repeat (300) begin @(negedge clk); if (tx === 1'b1) t++; end
        checks++; if (t != 0) $display("FAIL timeout_residue: tx high %0d cycles want 0", t); else passes++;
    endtask

    task automatic test_round_robin();
        bit ok; logic [31:0] len; logic [W-1:0] hdr; logic [7:0] act; int ncyc, bad, rr, es;
        logic [NS-1:0] masks[3];
        logic [NS-1:0] pend;
        masks[0] = 4'b1011; masks[1] = 4'b0101; masks[2] = 4'b1001;
        reset_dut();
        rr = 0;
        for (int r = 0; r < 3; r++) begin
            push_multi(masks[r], 32);
            pend = masks[r];
            while (pend != '0) begin
                es = rr_pick(rr, pend);
                collect(1'b0, ok, len, hdr, act, ncyc);
                checks++; if (!ok || hdr !== exp_hdr(es, 32))
                    $display("FAIL rr_order: round %0d got hdr %h want %h", r, hdr, exp_hdr(es, 32)); else passes++;
                bad = (got.size() != 32) ? 1 : 0;
                for (int k = 0; k < got.size() && mq[es].size() > 0; k++) if (got[k] !== mq[es].pop_front()) bad++;
                checks++; if (bad != 0) $display("FAIL rr_data: src %0d %0d bad want 0", es, bad); else passes++;
                pend[es] = 1'b0;
                rr = (es + 1) % NS;
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok; logic [31:0] len; logic [W-1:0] hdr; logic [7:0] act; int ncyc, bad;
        reset_dut();
        push_multi(4'b0010, 32);
        collect(1'b1, ok, len, hdr, act, ncyc);
        checks++; if (!ok || hdr !== exp_hdr(1, 32)) $display("FAIL bp_hdr: got %h want %h", hdr, exp_hdr(1, 32)); else passes++;
        checks++; if (ncyc != 63) $display("FAIL bp_hold: tx held %0d cycles want 63", ncyc); else passes++;
        bad = (got.size() != 32) ? 1 : 0;
        for (int k = 0; k < got.size() && mq[1].size() > 0; k++) if (got[k] !== mq[1].pop_front()) bad++;
        checks++; if (bad != 0) $display("FAIL bp_data: %0d bad of %0d beats want 0 of 32", bad, got.size()); else passes++;
    endtask

    task automatic test_fifo_full();
        bit ok; logic [31:0] len; logic [W-1:0] hdr; logic [7:0] act; int ncyc, bad, acc, occ_m, rbad, nfull, nxfer;
        logic [W-1:0] d;
        reset_dut();
        acc = 0; rbad = 0;
        for (int k = 0; k < DEPTH + 3; k++) begin
            d = {$urandom(), $urandom()};
            i_data[W +: W] = d; i_val = 4'b0010;
            if (i_rdy[1] !== (acc < DEPTH)) rbad++;
            if (i_rdy[1] === 1'b1) begin mq[1].push_back(d); acc++; end
            @(negedge clk);
        end
        i_val = '0;
        checks++; if (acc != DEPTH) $display("FAIL full_accepts: got %0d want %0d", acc, DEPTH); else passes++;
        checks++; if (i_rdy[1] !== 1'b0) $display("FAIL full_rdy: got %b want 0", i_rdy[1]); else passes++;
        checks++; if (rbad != 0) $display("FAIL full_rdy_track: %0d cycles wrong want 0", rbad); else passes++;
        // Drain the pending transfer while pushing every cycle.
        occ_m = DEPTH; rbad = 0; bad = 0;
        for (int c = 0; c <= MAXB; c++) begin
            d = {$urandom(), $urandom()};
            i_data[W +: W] = d; i_val = 4'b0010; ren = 1'b1;
            if (i_rdy[1] !== (occ_m < DEPTH)) rbad++;
            if (c >= 1 && mq[1].size() > 0 && tx_data !== mq[1].pop_front()) bad++;
            if (i_rdy[1] === 1'b1) mq[1].push_back(d);
            occ_m = occ_m + ((occ_m < DEPTH) ? 1 : 0) - ((c >= 1) ? 1 : 0);
            @(negedge clk);
        end
        i_val = '0; ren = 1'b0;
        checks++; if (rbad != 0 || bad != 0) $display("FAIL pushpop: rdy wrong %0d, data bad %0d, want 0/0", rbad, bad); else passes++;
        checks++; if (mq[1].size() != occ_m) $display("FAIL pushpop_occ: accepted model %0d want %0d", mq[1].size(), occ_m); else passes++;
        nfull = occ_m / MAXB; nxfer = 0; bad = 0;
        for (int x = 0; x < nfull; x++) begin
            collect(1'b0, ok, len, hdr, act, ncyc);
            if (ok && hdr === exp_hdr(1, 32) && got.size() == 32) nxfer++;
            for (int k = 0; k < got.size() && mq[1].size() > 0; k++) if (got[k] !== mq[1].pop_front()) bad++;
        end
        checks++; if (nxfer != nfull || bad != 0)
            $display("FAIL full_drain: %0d good transfers want %0d, %0d bad beats want 0", nxfer, nfull, bad); else passes++;
    endtask

    task automatic test_reset_mid();
        bit ok; logic [31:0] len; logic [W-1:0] hdr; logic [7:0] act; int ncyc, bad, t;
        reset_dut();
        push_multi(4'b1000, 32);
        t = 0;
        while (tx !== 1'b1 && t < 100) begin @(negedge clk); t++; end
        checks++; if (tx !== 1'b1) $display("FAIL mid_start: tx %b want 1", tx); else passes++;
        ren = 1'b1;
        repeat (11) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (tx !== 1'b0 || tx_dv !== 1'b0)
            $display("FAIL mid_abort: tx %b dv %b want 0 0", tx, tx_dv); else passes++;
        checks++; if (i_rdy !== '1) $display("FAIL mid_rdy: got %b want 1111", i_rdy); else passes++;
        rst = 1'b0; ren = 1'b0;
        for (int s = 0; s < NS; s++) mq[s].delete();
        t = 0;
        repeat (300) begin @(negedge clk); if (tx === 1'b1) t++; end
        checks++; if (t != 0) $display("FAIL mid_noelig: tx high %0d cycles want 0", t); else passes++;
        push_multi(4'b1000, 32);
        collect(1'b0, ok, len, hdr, act, ncyc);
        checks++; if (!ok || hdr !== exp_hdr(3, 32)) $display("FAIL mid_fresh_hdr: got %h want %h", hdr, exp_hdr(3, 32)); else passes++;
        bad = (got.size() != 32) ? 1 : 0;
        for (int k = 0; k < got.size() && mq[3].size() > 0; k++) if (got[k] !== mq[3].pop_front()) bad++;
        checks++; if (bad != 0) $display("FAIL mid_fresh_data: %0d bad want 0", bad); else passes++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_timeout();
        test_round_robin();
        test_backpressure();
        test_fifo_full();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/chnl_tx_mux.md
Name: chnl_tx_mux

Overview:
- Multi-source buffered RIFFA/CHNL transmitter: NUM_SRC independent C_PCI_DATA_WIDTH-wide input streams, each buffered in its own FIFO, time-shared onto one TX channel.
- Each transfer is one header beat (source id, payload length) followed by aligned payload beats from a single source.
- Round-robin arbitration among eligible sources; size-triggered and idle-timeout-triggered sends.
- Sits between per-stream producers (e.g. DRAM readback, trace capture) and the RIFFA core.

Parameters:
- C_PCI_DATA_WIDTH, 64, PCIe data width in bits; multiple of 32, at least 32.
- NUM_SRC, 4, number of input streams; 1..256.
- FIFO_DEPTH, 512, per-source FIFO depth in beats; power of 2, at least MAX_LENGTH*32/C_PCI_DATA_WIDTH.
- CHNL_ALIGN, 4, payload alignment in uint32; at least C_PCI_DATA_WIDTH/32.
- MAX_LENGTH, 64, maximum payload per transfer in uint32; multiple of CHNL_ALIGN.
- MAX_IDLE_CYCLES, 128, input-idle cycles before a partial send; 0 disables the timeout.

Ports:
- clk  in  1  single clock for all logic; CHNL_TX_CLK driven from it.
- rst  in  1  synchronous, active-high reset.
- i_val  in  NUM_SRC  per-source data valid.
- i_rdy  out  NUM_SRC  per-source ready; low when that source's FIFO is full.
- i_data  in  NUM_SRC*C_PCI_DATA_WIDTH  source s occupies bits [s*W +: W].
- CHNL_TX_CLK  out  1  equal to clk.
- CHNL_TX  out  1  transfer request (registered).
- CHNL_TX_ACK  in  1  ignored except for monitoring.
- CHNL_TX_LAST  out  1  constant 1.
- CHNL_TX_LEN  out  32  (1 + payload beats) * W/32; held stable while CHNL_TX is high.
- CHNL_TX_OFF  out  31  constant 0.
- CHNL_TX_DATA  out  W  header or FIFO-head data.
- CHNL_TX_DATA_VALID  out  1  beat valid.
- CHNL_TX_DATA_REN  in  1  beat consumed when high together with DATA_VALID.
- o_active_src  out  8  source being sent; 0 when idle.

Behaviour:
- Derived constants:
  - W = C_PCI_DATA_WIDTH.
  - ALIGN = CHNL_ALIGN*32/W beats.
  - MAX_BEATS = MAX_LENGTH*32/W.
- Input side:
  - A beat is accepted when i_val[s] and i_rdy[s] are both high.
  - Per-source occupancy counter: +1 on push, −1 on pop; a push and pop in the same cycle leave it unchanged.
  - The full FIFO_DEPTH beats are usable.
- Idle counter per source:
  - Cleared on accept and on grant.
  - Otherwise increments while i_val[s] is low, saturating at MAX_IDLE_CYCLES.
- A source is eligible in IDLE when either:
  - occupancy ≥ MAX_BEATS (payload = MAX_BEATS), or
  - MAX_IDLE_CYCLES≠0, idle ≥ MAX_IDLE_CYCLES and occupancy ≥ ALIGN (payload = occupancy rounded down to a multiple of ALIGN).
- Arbitration:
  - Round-robin search starting at rr_ptr.
  - After a transfer completes, rr_ptr = granted source + 1, wrapping at NUM_SRC.
- State machine (S_IDLE, S_HDR, S_DATA):
  - S_IDLE:
    - CHNL_TX=0, DATA_VALID=0.
    - If any source is eligible, latch src and payload, go to S_HDR.
    - CHNL_TX rises on the edge after eligibility (1-cycle latency).
  - S_HDR:
    - CHNL_TX=1, DATA_VALID=1.
    - Header beat: bits[7:0]=src; bits[31:8]=payload length in uint32; remaining bits 0.
    - On REN, go to S_DATA.
  - S_DATA:
    - DATA_VALID=1.
    - CHNL_TX_DATA is the head of FIFO[src]; REN pops it.
    - On the last payload beat with REN, go to S_IDLE; CHNL_TX falls on the same edge.
- Arrivals during a transfer are queued but do not extend the latched payload.
- Reset values:
  - CHNL_TX=0, DATA_VALID=0, o_active_src=0, rr_ptr=0.
  - All FIFOs and counters cleared; i_rdy=1 from the first cycle after reset.
- Reset asserted mid-transfer aborts it: at the next edge state=S_IDLE and CHNL_TX=0; queued data is discarded.

Optional Feature:
- Macro CHNL_TX_MUX_PAD_EN.
- Defined:
  - On idle timeout, payload = occupancy rounded up to a multiple of ALIGN.
  - Missing beats are emitted as all-zero beats after the FIFO drains; the header length includes the padding.
  - A timed-out source with occupancy ≥1 is eligible.
- Undefined: the remainder below ALIGN stays queued until more data arrives.

Test Plan:
- Single source, W=64, MAX_LENGTH=64: push 32 beats into src 2 → CHNL_TX rises 1 cycle later; LEN=66; header = 0x00004002; then 32 data beats in order.
- Idle timeout: push 5 beats into src 0, ALIGN=2, then wait 128 cycles → payload 4 beats, LEN=10, 1 beat left queued. With PAD_EN: payload 6 beats, LEN=14, last beat zero.
- Round-robin: srcs 0, 1, 3 all reach MAX_BEATS simultaneously → transfers ordered 0, 1, 3; then src 0 refilled → rr_ptr=0 after the src-3 transfer, so src 0 is next.
- Backpressure: REN toggled 1-0 every cycle during S_DATA → no beat lost or duplicated; CHNL_TX stays high until the last beat is consumed.
- FIFO full: push FIFO_DEPTH+3 beats to src 1 with the channel blocked → i_rdy[1] low after 512 accepts; simultaneous push/pop keeps occupancy exact.
- Reset mid-S_DATA after 10 beats → CHNL_TX=0 and DATA_VALID=0 at the next edge; all i_rdy=1; no eligible source until fresh data arrives.
